// File: rtl/test_card_sequencer.sv
// Test-card pattern generator with a manual/auto pattern sequencer.
// Four test patterns are produced through a fixed 2-stage colour pipeline.
// A two-state control FSM changes the pattern only on frame boundaries.
module test_card_sequencer #(
    parameter int H_RES              = 640,
    parameter int V_RES              = 480,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic        i_pix_clk,
    input  logic        i_rst,
    input  logic        i_frame,
    input  logic        i_de,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_next,
    input  logic        i_auto,
    output logic [1:0]  o_pattern,
    output logic [7:0]  o_frame_count,
    output logic        o_de,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue
);

    typedef enum logic {SHOW, ARMED} state_t;

    localparam int          H_BAND     = H_RES / 8;
    localparam int          V_BAND     = V_RES / 8;
    localparam logic [7:0]  LAST_FRAME = 8'(FRAMES_PER_PATTERN - 1);

    // Colour table shared by the vertical and horizontal band patterns.
    function automatic logic [23:0] band_colour(input logic [2:0] band);
        case (band)
            3'd0:    band_colour = 24'hFF0000;
            3'd1:    band_colour = 24'hFFFF00;
            3'd2:    band_colour = 24'h00FF00;
            3'd3:    band_colour = 24'h00FFFF;
            3'd4:    band_colour = 24'h0000FF;
            3'd5:    band_colour = 24'hFF00FF;
            3'd6:    band_colour = 24'h3F3F3F;
            default: band_colour = 24'h808080;
        endcase
    endfunction

    // ---------------- control ----------------
    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_pattern;
    logic [7:0]  r_frame_count;
    logic        w_advance;

    // Next-state logic: one advance per frame pulse, a request arms until then.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_advance    = i_frame && ((r_state == ARMED) || i_next ||
                                   (i_auto && (r_frame_count == LAST_FRAME)));
        if (w_advance) begin
            w_state_next = SHOW;
        end else if ((r_state == SHOW) && i_next && !i_frame) begin
            w_state_next = ARMED;
        end
    end

    // State, pattern index and frame counter registers; reset drops any pending request.
    always_ff @(posedge i_pix_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            r_state       <= SHOW;
            r_pattern     <= 2'd0;
            r_frame_count <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_advance) begin
                r_pattern     <= r_pattern + 2'd1;
                r_frame_count <= 8'd0;
            end else if (i_frame && (r_frame_count != 8'hFF)) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    // ---------------- stage 1: classification ----------------
    logic [2:0]  w_x_band;
    logic [2:0]  w_y_band;
    logic        w_x_out;
    logic        w_y_out;

    // Band index from comparisons against constant band edges (no divider).
    always_comb begin
        w_x_band = 3'd0;
        w_y_band = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (i_x >= 16'(k * H_BAND)) w_x_band = 3'(k);
            if (i_y >= 16'(k * V_BAND)) w_y_band = 3'(k);
        end
        w_x_out = (i_x >= 16'(H_RES));
        w_y_out = (i_y >= 16'(V_RES));
    end

    logic [1:0]  r_s1_pattern;
    logic        r_s1_de;
    logic [2:0]  r_s1_x_band;
    logic [2:0]  r_s1_y_band;
    logic        r_s1_x_out;
    logic        r_s1_y_out;
    logic        r_s1_check;
    logic [7:0]  r_s1_grey;

    // Stage 1 register: pattern in force for this pixel plus its classification.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_s1_pattern <= 2'd0;
            r_s1_de      <= 1'b0;
            r_s1_x_band  <= 3'd0;
            r_s1_y_band  <= 3'd0;
            r_s1_x_out   <= 1'b0;
            r_s1_y_out   <= 1'b0;
            r_s1_check   <= 1'b0;
            r_s1_grey    <= 8'd0;
        end else begin
            r_s1_pattern <= r_pattern;
            r_s1_de      <= i_de;
            r_s1_x_band  <= w_x_band;
            r_s1_y_band  <= w_y_band;
            r_s1_x_out   <= w_x_out;
            r_s1_y_out   <= w_y_out;
            r_s1_check   <= i_x[4] ^ i_y[4];
            r_s1_grey    <= i_x[7:0];
        end
    end

    // ---------------- stage 2: colour ----------------
    logic [23:0] w_colour;

    // Colour selection from the registered classification; blanked outside active video.
    always_comb begin
        w_colour = 24'h000000;
        if (r_s1_de) begin
            case (r_s1_pattern)
                2'd0:    w_colour = r_s1_x_out ? 24'h000000 : band_colour(r_s1_x_band);
                2'd1:    w_colour = r_s1_y_out ? 24'h000000 : band_colour(r_s1_y_band);
                2'd2:    w_colour = r_s1_check ? 24'hFFFFFF : 24'h000000;
                default: w_colour = {3{r_s1_grey}};
            endcase
        end
    end

    logic        r_de;
    logic [23:0] r_colour;

    // Stage 2 register: final colour and aligned data enable.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_de     <= 1'b0;
            r_colour <= 24'h000000;
        end else begin
            r_de     <= r_s1_de;
            r_colour <= w_colour;
        end
    end

    assign o_pattern     = r_pattern;
    assign o_frame_count = r_frame_count;
    assign o_de          = r_de;
    assign o_red         = r_colour[23:16];
    assign o_green       = r_colour[15:8];
    assign o_blue        = r_colour[7:0];

endmodule

// File: tb/tb_test_card_sequencer.sv
// Directed bench for test_card_sequencer with a pixel scoreboard.
// Inputs are driven on the falling edge; outputs are read on the falling edge.
module tb_test_card_sequencer;

    localparam int H = 640;
    localparam int V = 480;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0, i_frame = 1'b0, i_de = 1'b0, i_next = 1'b0, i_auto = 1'b0;
    logic [15:0] i_x = '0, i_y = '0;
    logic [1:0]  o_pattern;
    logic [7:0]  o_frame_count, o_red, o_green, o_blue;
    logic        o_de;

    test_card_sequencer #(.H_RES(H), .V_RES(V), .FRAMES_PER_PATTERN(3)) dut (
        .i_pix_clk(clk), .i_rst(i_rst), .i_frame(i_frame), .i_de(i_de),
        .i_x(i_x), .i_y(i_y), .i_next(i_next), .i_auto(i_auto),
        .o_pattern(o_pattern), .o_frame_count(o_frame_count), .o_de(o_de),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [24:0] sb[$];
    int          cur_pat = 0;
    logic        rst_lvl = 1'b0;
    logic        auto_lvl = 1'b0;
    string       tag = "init";

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [23:0] tbl(input int band);
        case (band)
            0: return 24'hFF0000;
            1: return 24'hFFFF00;
            2: return 24'h00FF00;
            3: return 24'h00FFFF;
            4: return 24'h0000FF;
            5: return 24'hFF00FF;
            6: return 24'h3F3F3F;
            default: return 24'h808080;
        endcase
    endfunction

    // Expected {de, r, g, b} for a pixel under a given pattern.
    function automatic logic [24:0] exp_pix(input int pat, input int x, input int y, input logic de);
        logic [23:0] c;
        logic [7:0]  g;
        if (!de) return 25'd0;
        case (pat)
            0: c = (x >= H) ? 24'h0 : tbl(x / (H / 8));
            1: c = (y >= V) ? 24'h0 : tbl(y / (V / 8));
            2: c = ((((x / 16) + (y / 16)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            default: begin
                g = 8'(x % 256);
                c = {g, g, g};
            end
        endcase
        return {1'b1, c};
    endfunction

    // One clock: compare the output due now, then drive the next input set.
    task automatic cyc(input int x, input int y, input logic de, input logic nxt, input logic frm);
        logic [24:0] e;
        @(negedge clk);
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check({tag, "_pix"}, 32'({o_de, o_red, o_green, o_blue}), 32'(e));
        end
        i_x = 16'(x); i_y = 16'(y); i_de = de; i_next = nxt; i_frame = frm;
        i_auto = auto_lvl; i_rst = rst_lvl;
        if (rst_lvl) foreach (sb[i]) sb[i] = 25'd0;
        sb.push_back(rst_lvl ? 25'd0 : exp_pix(cur_pat, x, y, de));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic state_is(input string name, input int pat, input int fc);
        check({name, "_pattern"}, 32'(o_pattern), 32'(pat));
        check({name, "_fcount"}, 32'(o_frame_count), 32'(fc));
    endtask

    initial begin
        // Reset state
        tag = "reset";
        rst_lvl = 1'b1; idle(3);
        rst_lvl = 1'b0; idle(1);
        state_is("reset", 0, 0);
        check("reset_out", 32'({o_de, o_red, o_green, o_blue}), 32'd0);

        // Latency and pattern-0 bands
        tag = "lat";
        cyc(0, 0, 1, 0, 0);
        cyc(80, 0, 1, 0, 0);
        cyc(560, 0, 1, 0, 0);
        cyc(639, 0, 1, 0, 0);
        cyc(640, 0, 1, 0, 0);
        cyc(200, 0, 0, 0, 0);
        idle(2);

        // Manual advance with a redundant second request
        tag = "man";
        cyc(0, 0, 0, 1, 0);
        idle(1);
        state_is("man_hold", 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        state_is("man_armed", 0, 0);
        cyc(0, 60, 1, 0, 1);          // frame cycle pixel still uses pattern 0
        cur_pat = 1;
        cyc(0, 60, 1, 0, 0);          // first pixel of new pattern
        state_is("man_step", 1, 0);
        cyc(0, 480, 1, 0, 0);
        cyc(0, 479, 1, 0, 1);
        idle(1);
        state_is("man_once", 1, 1);

        // Checkerboard and grey ramp boundaries
        tag = "pat";
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cur_pat = 2;
        cyc(15, 0, 1, 0, 0);
        cyc(16, 0, 1, 0, 0);
        cyc(16, 16, 1, 0, 0);
        state_is("pat2", 2, 0);
        cyc(0, 0, 0, 1, 1);           // request and frame together
        cur_pat = 3;
        cyc(300, 0, 1, 0, 0);
        cyc(255, 9, 1, 0, 0);
        state_is("pat3", 3, 0);
        cyc(0, 0, 0, 1, 1);
        cur_pat = 0;
        idle(2);
        state_is("wrap", 0, 0);

        // Auto mode, 3 frames per pattern
        tag = "auto";
        auto_lvl = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, 1);
            cur_pat = ((i + 1) / 3) % 4;
            idle(1);
            state_is($sformatf("auto%0d", i), cur_pat, (i + 1) % 3);
        end

        // Request coincident with auto terminal count
        tag = "coin";
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        idle(1);
        state_is("coin_pre", 0, 2);
        cyc(0, 0, 0, 1, 1);
        cur_pat = 1;
        idle(1);
        state_is("coin", 1, 0);
        cyc(0, 0, 0, 0, 1);
        idle(1);
        state_is("coin_after", 1, 1);

        // Auto toggled off: count kept, manual-only stepping, saturation
        tag = "sat";
        auto_lvl = 1'b0;
        idle(1);
        state_is("auto_off", 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        idle(1);
        state_is("no_auto", 1, 4);
        for (int i = 0; i < 260; i++) cyc(0, 0, 0, 0, 1);
        idle(1);
        state_is("saturate", 1, 255);

        // Reset while armed discards the request
        tag = "rst";
        cyc(0, 0, 0, 1, 1);
        cur_pat = 2;
        cyc(0, 0, 0, 1, 0);
        idle(1);
        state_is("rst_armed", 2, 0);
        rst_lvl = 1'b1; idle(2);
        rst_lvl = 1'b0; cur_pat = 0; idle(1);
        state_is("rst_clr", 0, 0);
        cyc(0, 0, 0, 0, 1);
        idle(1);
        state_is("rst_noadv", 0, 1);

        // Reset wins over same-cycle frame and request
        rst_lvl = 1'b1;
        cyc(0, 0, 1, 1, 1);
        rst_lvl = 1'b0;
        idle(1);
        state_is("rst_prio", 0, 0);
        cyc(0, 0, 0, 0, 1);
        idle(1);
        state_is("rst_prio_after", 0, 1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
